// File: rtl/maze_mem_arbiter_if.sv
// ============================================================================
// Module   : maze_mem_arbiter_if
// Purpose  : Requester handshake and maze-memory bus bundle for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface maze_mem_arbiter_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 1
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] x0;
   logic [ADDR_W-1:0] y0;
   logic [ADDR_W-1:0] x1;
   logic [ADDR_W-1:0] y1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_x;
   logic [ADDR_W-1:0] mem_y;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   logic              busy;
   logic              grant_id;

   modport slave (
      input  req0, req1, we0, we1, x0, y0, x1, y1, wdata0, wdata1, mem_dout,
      output ack0, ack1, rdata0, rdata1, mem_rd, mem_wr, mem_x, mem_y, mem_din,
             busy, grant_id
   );

   modport master (
      output req0, req1, we0, we1, x0, y0, x1, y1, wdata0, wdata1, mem_dout,
      input  ack0, ack1, rdata0, rdata1, mem_rd, mem_wr, mem_x, mem_y, mem_din,
             busy, grant_id
   );
endinterface

`default_nettype wire

// File: rtl/maze_mem_arbiter.sv
// ============================================================================
// Module   : maze_mem_arbiter
// Purpose  : Two-port req/ack arbiter for the single-port 16x16 maze memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_mem_arbiter #(
   parameter int ADDR_W        = 4,
   parameter int DATA_W        = 1,
   parameter int PRIORITY_MODE = 0,
   parameter int MAX_WAIT      = 8
) (
   input  logic              clock,
   input  logic              reset,
   maze_mem_arbiter_if.slave bus
);

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_ISSUE    = 2'd1;
   localparam logic [1:0] c_COMPLETE = 2'd2;
   localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

   logic [1:0]        r_state;
   logic              r_grant;
   logic              r_last;
   logic [3:0]        r_wait1;
   logic              r_ack0;
   logic              r_ack1;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [ADDR_W-1:0] r_mem_x;
   logic [ADDR_W-1:0] r_mem_y;
   logic [DATA_W-1:0] r_mem_din;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic              r_busy;

   logic              w_any;
   logic              w_sel1;
   logic              w_we;
   logic [ADDR_W-1:0] w_x;
   logic [ADDR_W-1:0] w_y;
   logic [DATA_W-1:0] w_din;

   always_comb begin
      w_any  = bus.req0 | bus.req1;
      w_sel1 = 1'b0;
      if (bus.req1 && !bus.req0) begin
         w_sel1 = 1'b1;
      end else if (bus.req1 && bus.req0) begin
         // Round-robin favours whichever port was not served last.
         if (PRIORITY_MODE == 0) w_sel1 = ~r_last;
         else                    w_sel1 = (r_wait1 >= c_MAX_WAIT);
      end
      w_we  = w_sel1 ? bus.we1    : bus.we0;
      w_x   = w_sel1 ? bus.x1     : bus.x0;
      w_y   = w_sel1 ? bus.y1     : bus.y0;
      w_din = w_sel1 ? bus.wdata1 : bus.wdata0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= c_IDLE;
         r_grant   <= 1'b0;
         r_last    <= 1'b1;
         r_wait1   <= 4'd0;
         r_ack0    <= 1'b0;
         r_ack1    <= 1'b0;
         r_mem_rd  <= 1'b0;
         r_mem_wr  <= 1'b0;
         r_mem_x   <= '0;
         r_mem_y   <= '0;
         r_mem_din <= '0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_any) begin
                  r_state   <= c_ISSUE;
                  r_grant   <= w_sel1;
                  r_mem_rd  <= ~w_we;
                  r_mem_wr  <= w_we;
                  r_mem_x   <= w_x;
                  r_mem_y   <= w_y;
                  r_mem_din <= w_din;
                  r_busy    <= 1'b1;
               end
               // Starvation counter only tracks port 1 losing while asking.
               if (bus.req1 && w_sel1) begin
                  r_wait1 <= 4'd0;
               end else if (bus.req1 && r_wait1 != 4'd15) begin
                  r_wait1 <= r_wait1 + 4'd1;
               end
            end
            c_ISSUE: begin
               if (r_mem_rd) begin
                  if (r_grant) r_rdata1 <= bus.mem_dout;
                  else         r_rdata0 <= bus.mem_dout;
               end
               r_mem_rd <= 1'b0;
               r_mem_wr <= 1'b0;
               r_ack0   <= ~r_grant;
               r_ack1   <= r_grant;
               r_state  <= c_COMPLETE;
            end
            c_COMPLETE: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_busy  <= 1'b0;
               r_last  <= r_grant;
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign bus.ack0     = r_ack0;
   assign bus.ack1     = r_ack1;
   assign bus.rdata0   = r_rdata0;
   assign bus.rdata1   = r_rdata1;
   assign bus.mem_rd   = r_mem_rd;
   assign bus.mem_wr   = r_mem_wr;
   assign bus.mem_x    = r_mem_x;
   assign bus.mem_y    = r_mem_y;
   assign bus.mem_din  = r_mem_din;
   assign bus.busy     = r_busy;
   assign bus.grant_id = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_maze_mem_arbiter.sv
// ============================================================================
// Module   : tb_maze_mem_arbiter
// Purpose  : Directed self-checking bench for the maze memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maze_mem_arbiter;

   typedef struct {
      logic       req0, req1, we0, we1;
      logic [3:0] x0, y0, x1, y1;
      logic       wd0, wd1;
      logic       g, rd, wr;
      logic [3:0] ex, ey;
      logic       edin, er0, er1;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic mem_init = 1'b0;
   logic [255:0] mem_rr;
   logic [255:0] mem_fp;
   int n_tests = 0;
   int n_fail  = 0;
   vec_t vecs [0:8];

   always #5 clock = ~clock;

   maze_mem_arbiter_if #(.ADDR_W(4), .DATA_W(1)) bus_rr ();
   maze_mem_arbiter_if #(.ADDR_W(4), .DATA_W(1)) bus_fp ();

   maze_mem_arbiter #(.ADDR_W(4), .DATA_W(1), .PRIORITY_MODE(0), .MAX_WAIT(8))
      dut_rr (.clock(clock), .reset(reset), .bus(bus_rr));
   maze_mem_arbiter #(.ADDR_W(4), .DATA_W(1), .PRIORITY_MODE(1), .MAX_WAIT(2))
      dut_fp (.clock(clock), .reset(reset), .bus(bus_fp));

   // Behavioural maze memories: combinational read, write on the clock edge.
   assign bus_rr.mem_dout = mem_rr[{bus_rr.mem_y, bus_rr.mem_x}];
   assign bus_fp.mem_dout = mem_fp[{bus_fp.mem_y, bus_fp.mem_x}];

   always @(posedge clock) begin
      if (mem_init) begin
         mem_rr     <= '0;
         mem_rr[83] <= 1'b1;
         mem_fp     <= '0;
      end
      if (bus_rr.mem_wr) mem_rr[{bus_rr.mem_y, bus_rr.mem_x}] <= bus_rr.mem_din;
      if (bus_fp.mem_wr) mem_fp[{bus_fp.mem_y, bus_fp.mem_x}] <= bus_fp.mem_din;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int r0, r1, w0, w1, ax0, ay0, ax1, ay1, d0, d1,
                               input int g, rd, wr, ex, ey, edin, er0, er1);
      vec_t v;
      v.req0 = 1'(r0);  v.req1 = 1'(r1);  v.we0 = 1'(w0);  v.we1 = 1'(w1);
      v.x0 = 4'(ax0);   v.y0 = 4'(ay0);   v.x1 = 4'(ax1);  v.y1 = 4'(ay1);
      v.wd0 = 1'(d0);   v.wd1 = 1'(d1);
      v.g = 1'(g);      v.rd = 1'(rd);    v.wr = 1'(wr);
      v.ex = 4'(ex);    v.ey = 4'(ey);    v.edin = 1'(edin);
      v.er0 = 1'(er0);  v.er1 = 1'(er1);
      return v;
   endfunction

   task automatic idle_inputs();
      bus_rr.req0 = 0; bus_rr.req1 = 0; bus_rr.we0 = 0; bus_rr.we1 = 0;
      bus_rr.x0 = 0; bus_rr.y0 = 0; bus_rr.x1 = 0; bus_rr.y1 = 0;
      bus_rr.wdata0 = 0; bus_rr.wdata1 = 0;
      bus_fp.req0 = 0; bus_fp.req1 = 0; bus_fp.we0 = 0; bus_fp.we1 = 0;
      bus_fp.x0 = 0; bus_fp.y0 = 0; bus_fp.x1 = 0; bus_fp.y1 = 0;
      bus_fp.wdata0 = 0; bus_fp.wdata1 = 0;
   endtask

   initial begin
      int n_a0, n_a1, n_busy, k;
      int g_ids [0:5];
      int g_cyc [0:5];

      //        r0 r1 w0 w1 x0 y0 x1 y1 d0 d1  g rd wr ex ey din r0 r1
      vecs[0] = mk(1, 0, 0, 0, 3, 5, 0, 0, 0, 0, 0, 1, 0, 3, 5, 0, 1, 0);
      vecs[1] = mk(0, 1, 0, 1, 0, 0,15,15, 0, 1, 1, 0, 1,15,15, 1, 1, 0);
      vecs[2] = mk(1, 0, 0, 0,15,15, 0, 0, 0, 0, 0, 1, 0,15,15, 0, 1, 0);
      vecs[3] = mk(1, 1, 0, 0, 0, 0,15,15, 0, 0, 1, 1, 0,15,15, 0, 1, 1);
      vecs[4] = mk(1, 1, 0, 0, 0, 0,15,15, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      vecs[5] = mk(0, 1, 0, 1, 0, 0, 3, 5, 0, 0, 1, 0, 1, 3, 5, 0, 0, 1);
      vecs[6] = mk(0, 1, 0, 0, 0, 0, 3, 5, 0, 0, 1, 1, 0, 3, 5, 0, 0, 0);
      vecs[7] = mk(1, 0, 1, 0, 7, 2, 0, 0, 1, 0, 0, 0, 1, 7, 2, 1, 0, 0);
      vecs[8] = mk(0, 1, 0, 0, 0, 0, 7, 2, 0, 0, 1, 1, 0, 7, 2, 0, 0, 1);

      idle_inputs();
      reset = 1'b0;
      mem_init = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_state",
            {bus_rr.ack0, bus_rr.ack1, bus_rr.mem_rd, bus_rr.mem_wr, bus_rr.busy,
             bus_rr.grant_id, bus_rr.mem_x, bus_rr.mem_y, bus_rr.mem_din,
             bus_rr.rdata0, bus_rr.rdata1}, 32'd0);
      mem_init = 1'b0;
      reset = 1'b1;

      // Single transactions, one per 3 cycles.
      for (int i = 0; i < 9; i++) begin
         bus_rr.req0 = vecs[i].req0;  bus_rr.req1 = vecs[i].req1;
         bus_rr.we0  = vecs[i].we0;   bus_rr.we1  = vecs[i].we1;
         bus_rr.x0   = vecs[i].x0;    bus_rr.y0   = vecs[i].y0;
         bus_rr.x1   = vecs[i].x1;    bus_rr.y1   = vecs[i].y1;
         bus_rr.wdata0 = vecs[i].wd0; bus_rr.wdata1 = vecs[i].wd1;
         @(posedge clock);
         @(negedge clock);
         check($sformatf("issue_v%0d", i),
               {bus_rr.grant_id, bus_rr.mem_rd, bus_rr.mem_wr, bus_rr.mem_x,
                bus_rr.mem_y, bus_rr.mem_din, bus_rr.busy},
               {vecs[i].g, vecs[i].rd, vecs[i].wr, vecs[i].ex, vecs[i].ey,
                vecs[i].edin, 1'b1});
         @(negedge clock);
         check($sformatf("ack_v%0d", i),
               {bus_rr.ack0, bus_rr.ack1, bus_rr.mem_rd, bus_rr.mem_wr, bus_rr.busy},
               {~vecs[i].g, vecs[i].g, 1'b0, 1'b0, 1'b1});
         check($sformatf("rdata_v%0d", i), {bus_rr.rdata0, bus_rr.rdata1},
               {vecs[i].er0, vecs[i].er1});
         @(posedge clock);
         #1 idle_inputs();
      end

      // Round-robin with both requests held: 0,1,0,1, acks 3 cycles apart.
      bus_rr.req0 = 1; bus_rr.req1 = 1;
      k = 0; n_busy = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         if (bus_rr.busy) n_busy++;
         if ((bus_rr.ack0 || bus_rr.ack1) && k < 6) begin
            g_ids[k] = bus_rr.ack1 ? 1 : 0;
            g_cyc[k] = c;
            k++;
         end
      end
      @(posedge clock);
      #1 idle_inputs();
      check("rr_ack_count", k, 4);
      check("rr_busy_cycles", n_busy, 8);
      for (int j = 0; j < 4; j++) begin
         if (j < k) check($sformatf("rr_grant%0d", j), g_ids[j], j % 2);
         else       check($sformatf("rr_grant%0d_missing", j), 32'd1, 32'd0);
      end
      for (int j = 1; j < 4; j++) begin
         if (j < k) check($sformatf("rr_spacing%0d", j), g_cyc[j] - g_cyc[j-1], 3);
      end

      // Fixed priority, MAX_WAIT=2: grants 0,0,1,0,0,1.
      bus_fp.req0 = 1; bus_fp.req1 = 1;
      bus_fp.x1 = 4'd9; bus_fp.y1 = 4'd9;
      k = 0;
      for (int c = 0; c < 18; c++) begin
         @(negedge clock);
         if ((bus_fp.ack0 || bus_fp.ack1) && k < 6) begin
            g_ids[k] = bus_fp.ack1 ? 1 : 0;
            k++;
         end
      end
      @(posedge clock);
      #1 idle_inputs();
      check("fp_ack_count", k, 6);
      for (int j = 0; j < 6; j++) begin
         if (j < k) check($sformatf("fp_grant%0d", j), g_ids[j], (j % 3 == 2) ? 1 : 0);
      end

      // Both request, port 1 withdraws before its turn: only ack0.
      bus_rr.req0 = 1; bus_rr.req1 = 1;
      n_a0 = 0; n_a1 = 0; n_busy = 0;
      @(posedge clock);
      #1 bus_rr.req1 = 0;
      repeat (2) begin
         @(negedge clock);
         if (bus_rr.ack0) n_a0++;
         if (bus_rr.ack1) n_a1++;
      end
      @(posedge clock);
      #1 bus_rr.req0 = 0;
      repeat (6) begin
         @(negedge clock);
         if (bus_rr.ack0) n_a0++;
         if (bus_rr.ack1) n_a1++;
         if (bus_rr.busy) n_busy++;
      end
      check("withdraw_ack0", n_a0, 1);
      check("withdraw_ack1", n_a1, 0);
      check("withdraw_idle_busy", n_busy, 0);

      // Reset during ISSUE of a port-1 read aborts it.
      @(posedge clock);
      #1 begin bus_rr.req1 = 1; bus_rr.x1 = 4'd15; bus_rr.y1 = 4'd15; end
      @(posedge clock);
      @(negedge clock);
      check("abort_issue", {bus_rr.mem_rd, bus_rr.grant_id}, 2'b11);
      #2 reset = 1'b0;
      #1 check("abort_async", {bus_rr.mem_rd, bus_rr.busy, bus_rr.grant_id}, 3'b000);
      bus_rr.req1 = 0;
      @(negedge clock);
      reset = 1'b1;
      n_a1 = 0;
      repeat (4) begin
         @(negedge clock);
         if (bus_rr.ack1) n_a1++;
      end
      check("abort_no_ack1", n_a1, 0);
      @(posedge clock);
      #1 begin bus_rr.req0 = 1; bus_rr.x0 = 4'd7; bus_rr.y0 = 4'd2; end
      @(posedge clock);
      @(negedge clock);
      check("post_reset_issue", {bus_rr.mem_rd, bus_rr.mem_x, bus_rr.mem_y},
            {1'b1, 4'd7, 4'd2});
      @(negedge clock);
      check("post_reset_ack", {bus_rr.ack0, bus_rr.ack1, bus_rr.rdata0}, 3'b101);
      @(posedge clock);
      #1 idle_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
